// File: rtl/wb_ram_dual_arbiter_pkg.sv
// Shared definitions for the dual-master Wishbone RAM arbiter.
// WB_RAM_ARB_BURST_EN adds the BURST state and the cycle-type constants.
package wb_ram_dual_arbiter_pkg;

`ifdef WB_RAM_ARB_BURST_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ADDR  = 2'd1,
    ST_ACK   = 2'd2,
    ST_BURST = 2'd3
  } state_t;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_ACK  = 2'd2
  } state_t;
`endif

  // Word-address width for a RAM of the given depth (at least one bit).
  function automatic int addr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/wb_ram_rr_arbiter.sv
// Two-way round-robin arbiter: on a tie the master that did not win last time
// is granted. Purely combinational; the caller holds last_grant.
module wb_ram_rr_arbiter (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic [1:0] grant_o
);

  // One-hot grant; a lone requester always wins, ties go away from last_grant
  always_comb begin
    grant_o = 2'b00;
    case (req_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = last_grant_i ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/wb_ram_dual_arbiter.sv
// Two Wishbone B4 classic slave ports sharing one word RAM with byte-enable
// writes and a one-cycle registered read. Every single transfer takes
// IDLE -> ADDR -> ACK and is re-arbitrated round-robin.
// Optional: define WB_RAM_ARB_BURST_EN for incrementing bursts (cti=010).
module wb_ram_dual_arbiter
  import wb_ram_dual_arbiter_pkg::*;
#(
  parameter  int depth = 256,
  localparam int AW    = addr_w(depth)
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic [31:0]   wbs0_adr_i,
  input  logic [31:0]   wbs0_dat_i,
  input  logic [3:0]    wbs0_sel_i,
  input  logic          wbs0_we_i,
  input  logic          wbs0_cyc_i,
  input  logic          wbs0_stb_i,
  input  logic [2:0]    wbs0_cti_i,
  output logic [31:0]   wbs0_dat_o,
  output logic          wbs0_ack_o,
  input  logic [31:0]   wbs1_adr_i,
  input  logic [31:0]   wbs1_dat_i,
  input  logic [3:0]    wbs1_sel_i,
  input  logic          wbs1_we_i,
  input  logic          wbs1_cyc_i,
  input  logic          wbs1_stb_i,
  input  logic [2:0]    wbs1_cti_i,
  output logic [31:0]   wbs1_dat_o,
  output logic          wbs1_ack_o,
  output logic [3:0]    ram_we_o,
  output logic [31:0]   ram_din_o,
  output logic [AW-1:0] ram_waddr_o,
  output logic [AW-1:0] ram_raddr_o,
  input  logic [31:0]   ram_dout_i
);

  logic [1:0]    req;
  logic [1:0]    arb_grant;
  logic [AW-1:0] word0, word1;

  state_t        state_q, state_d;
  logic          gnt_q, gnt_d;             // index of the master owning the RAM
  logic          last_grant_q, last_grant_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [AW-1:0] raddr_q, raddr_d;
  logic [31:0]   din_q, din_d;

  logic          req_g, we_g;
  logic [3:0]    sel_g;
  logic [31:0]   dat_g;

  logic [3:0]    we_c;
  logic [31:0]   din_c;
  logic [AW-1:0] waddr_c, raddr_c;
  logic          ack_c;

  // Address LSBs and bits above the RAM window are ignored (addresses wrap)
  logic unused_bits;
  assign unused_bits = ^{wbs0_adr_i[31:AW+2], wbs0_adr_i[1:0],
                         wbs1_adr_i[31:AW+2], wbs1_adr_i[1:0],
                         wbs0_cti_i, wbs1_cti_i};

  assign req   = {wbs1_cyc_i & wbs1_stb_i, wbs0_cyc_i & wbs0_stb_i};
  assign word0 = wbs0_adr_i[AW+1:2];
  assign word1 = wbs1_adr_i[AW+1:2];

  wb_ram_rr_arbiter u_arb (
    .req_i        (req),
    .last_grant_i (last_grant_q),
    .grant_o      (arb_grant)
  );

`ifdef WB_RAM_ARB_BURST_EN
  logic [AW-1:0] cur_q, cur_d;             // word of the current burst beat
  logic [2:0]    cti_g;

  function automatic logic [AW-1:0] next_word(input logic [AW-1:0] w);
    if (w == AW'(depth - 1)) return '0;
    return w + 1'b1;
  endfunction
`endif

  // Bus signals of whichever master currently owns the RAM
  always_comb begin
    req_g = gnt_q ? req[1]     : req[0];
    we_g  = gnt_q ? wbs1_we_i  : wbs0_we_i;
    sel_g = gnt_q ? wbs1_sel_i : wbs0_sel_i;
    dat_g = gnt_q ? wbs1_dat_i : wbs0_dat_i;
`ifdef WB_RAM_ARB_BURST_EN
    cti_g = gnt_q ? wbs1_cti_i : wbs0_cti_i;
`endif
  end

  // Next state and RAM/ack strobes; RAM ports hold their last value by default
  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    last_grant_d = last_grant_q;
    waddr_d      = waddr_q;
    raddr_d      = raddr_q;
    din_d        = din_q;
    we_c         = 4'h0;
    din_c        = din_q;
    waddr_c      = waddr_q;
    raddr_c      = raddr_q;
    ack_c        = 1'b0;
`ifdef WB_RAM_ARB_BURST_EN
    cur_d        = cur_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (|arb_grant) begin
          gnt_d   = ~arb_grant[0];
          waddr_d = arb_grant[0] ? word0 : word1;
          raddr_d = arb_grant[0] ? word0 : word1;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (!req_g) begin
          state_d = ST_IDLE;
        end else begin
          if (we_g) begin
            we_c  = sel_g;
            din_c = dat_g;
            din_d = dat_g;
          end
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        ack_c        = req_g;
        last_grant_d = gnt_q;
        state_d      = ST_IDLE;
`ifdef WB_RAM_ARB_BURST_EN
        // Incrementing burst: prefetch the next word so it is ready next beat
        if (req_g && cti_g == CTI_INCR) begin
          raddr_c = next_word(waddr_q);
          raddr_d = next_word(waddr_q);
          cur_d   = next_word(waddr_q);
          state_d = ST_BURST;
        end
`endif
      end
`ifdef WB_RAM_ARB_BURST_EN
      ST_BURST: begin
        if (!req_g) begin
          state_d = ST_IDLE;
        end else begin
          ack_c   = 1'b1;
          waddr_c = cur_q;
          waddr_d = cur_q;
          raddr_c = next_word(cur_q);
          raddr_d = next_word(cur_q);
          cur_d   = next_word(cur_q);
          if (we_g) begin
            we_c  = sel_g;
            din_c = dat_g;
            din_d = dat_g;
          end
          if (cti_g == CTI_END || cti_g == CTI_CLASSIC) state_d = ST_IDLE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // State and held RAM port values; reset abandons any transfer in flight
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q      <= ST_IDLE;
      gnt_q        <= 1'b0;
      last_grant_q <= 1'b1;
      waddr_q      <= '0;
      raddr_q      <= '0;
      din_q        <= '0;
`ifdef WB_RAM_ARB_BURST_EN
      cur_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      last_grant_q <= last_grant_d;
      waddr_q      <= waddr_d;
      raddr_q      <= raddr_d;
      din_q        <= din_d;
`ifdef WB_RAM_ARB_BURST_EN
      cur_q        <= cur_d;
`endif
    end
  end

  assign ram_we_o    = we_c;
  assign ram_din_o   = din_c;
  assign ram_waddr_o = waddr_c;
  assign ram_raddr_o = raddr_c;

  assign wbs0_ack_o  = ack_c & ~gnt_q;
  assign wbs1_ack_o  = ack_c &  gnt_q;
  assign wbs0_dat_o  = wbs0_ack_o ? ram_dout_i : 32'h0;
  assign wbs1_dat_o  = wbs1_ack_o ? ram_dout_i : 32'h0;

endmodule

// File: tb/tb_wb_ram_dual_arbiter.sv
// Bench for wb_ram_dual_arbiter (default build): RAM model, two masters,
// and a transaction-level reference (word memory + arbitration rules).
module tb_wb_ram_dual_arbiter;

  localparam int DEPTH = 256;
  localparam int AW    = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] adr   [2];
  logic [31:0] dat_i [2];
  logic [3:0]  sel   [2];
  logic        we    [2];
  logic        cyc   [2];
  logic        stb   [2];
  logic [2:0]  cti   [2];
  logic [31:0] dat_o [2];
  logic        ack   [2];

  logic [3:0]    ram_we;
  logic [31:0]   ram_din;
  logic [AW-1:0] ram_waddr, ram_raddr;
  logic [31:0]   ram_dout = '0;

  wb_ram_dual_arbiter #(.depth(DEPTH)) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .wbs0_adr_i  (adr[0]),
    .wbs0_dat_i  (dat_i[0]),
    .wbs0_sel_i  (sel[0]),
    .wbs0_we_i   (we[0]),
    .wbs0_cyc_i  (cyc[0]),
    .wbs0_stb_i  (stb[0]),
    .wbs0_cti_i  (cti[0]),
    .wbs0_dat_o  (dat_o[0]),
    .wbs0_ack_o  (ack[0]),
    .wbs1_adr_i  (adr[1]),
    .wbs1_dat_i  (dat_i[1]),
    .wbs1_sel_i  (sel[1]),
    .wbs1_we_i   (we[1]),
    .wbs1_cyc_i  (cyc[1]),
    .wbs1_stb_i  (stb[1]),
    .wbs1_cti_i  (cti[1]),
    .wbs1_dat_o  (dat_o[1]),
    .wbs1_ack_o  (ack[1]),
    .ram_we_o    (ram_we),
    .ram_din_o   (ram_din),
    .ram_waddr_o (ram_waddr),
    .ram_raddr_o (ram_raddr),
    .ram_dout_i  (ram_dout)
  );

  // RAM: byte-enable write, registered read returning the pre-write contents
  logic [31:0] ram [DEPTH] = '{default: '0};
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (ram_we[b]) ram[ram_waddr][8*b +: 8] <= ram_din[8*b +: 8];
    ram_dout <= ram[ram_raddr];
  end

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  // Reference: memory image as seen through completed transfers, plus
  // per-master request bookkeeping for latency and fairness rules.
  logic [31:0]   exp_mem [DEPTH] = '{default: '0};
  logic          mreq [2];
  bit            pend [2];
  int            start [2];
  bit            oseen [2];
  int            last_ack_m   = -1;
  int            last_ack_cyc = -10;
  int            ackq [$];
  logic [AW-1:0] last_we_addr = '0;
  logic [AW-1:0] w;
  int            lat_m;
  bit            we_ok, starved;

  always @(negedge clk) begin
    if (!rst) begin
      for (int m = 0; m < 2; m++) mreq[m] = cyc[m] & stb[m];
      for (int m = 0; m < 2; m++) begin
        if (!mreq[m]) pend[m] = 1'b0;
        else if (!pend[m]) begin
          pend[m] = 1'b1; start[m] = cyc_cnt; oseen[m] = mreq[1-m];
        end else oseen[m] = oseen[m] | mreq[1-m];
      end
      check("ack_excl", 32'(ack[0] & ack[1]), 0);
      for (int m = 0; m < 2; m++) begin
        check($sformatf("ack_gate%0d", m), 32'(ack[m] & ~mreq[m]), 0);
        if (!ack[m]) check($sformatf("dat_idle%0d", m), dat_o[m], 0);
      end
      if (ram_we != 4'h0) begin
        we_ok = 1'b0;
        for (int m = 0; m < 2; m++)
          if (mreq[m] && we[m] && sel[m] == ram_we && adr[m][AW+1:2] == ram_waddr &&
              dat_i[m] == ram_din) we_ok = 1'b1;
        check("we_src", 32'(we_ok), 1);
        check("we_in_ack", 32'(ack[0] | ack[1]), 0);
        last_we_addr = ram_waddr;
      end
      for (int m = 0; m < 2; m++) begin
        if (ack[m] && mreq[m]) begin
          lat_m = cyc_cnt - start[m];
          check($sformatf("lat_range%0d", m), 32'(lat_m >= 2 && lat_m <= 5), 1);
          if (!oseen[m]) check($sformatf("lat_idle%0d", m), lat_m, 2);
          starved = (last_ack_m == m) && pend[1-m] && (start[1-m] <= last_ack_cyc + 1);
          check("rr_fair", 32'(starved), 0);
          w = adr[m][AW+1:2];
          if (we[m]) begin
            for (int b = 0; b < 4; b++)
              if (sel[m][b]) exp_mem[w][8*b +: 8] = dat_i[m][8*b +: 8];
          end else begin
            check($sformatf("rd_data%0d", m), dat_o[m], exp_mem[w]);
          end
          ackq.push_back(m);
          last_ack_m   = m;
          last_ack_cyc = cyc_cnt;
          pend[m]      = 1'b0;
        end
      end
    end
  end

  // One single transfer on master m; call just after a rising edge
  task automatic xfer(input int m, input logic [31:0] a, input logic wr, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] rd, output int lat);
    int t0;
    bit got;
    adr[m] = a; we[m] = wr; dat_i[m] = d; sel[m] = s; cyc[m] = 1'b1; stb[m] = 1'b1;
    t0 = cyc_cnt; got = 1'b0; lat = -1; rd = '0;
    for (int i = 0; i < 12 && !got; i++) begin
      @(negedge clk);
      if (ack[m]) begin
        got = 1'b1; rd = dat_o[m]; lat = cyc_cnt - t0;
      end
    end
    check($sformatf("xfer_ack%0d", m), 32'(got), 1);
    @(posedge clk); #1;
    cyc[m] = 1'b0; stb[m] = 1'b0; we[m] = 1'b0;
  endtask

  task automatic rand_master(input int m, input int n);
    logic [31:0] rd, a;
    int lat, gap;
    for (int i = 0; i < n; i++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) begin @(posedge clk); #1; end
      a = ($urandom & 32'hFFFF_FC03) | (32'($urandom_range(0, 7)) << 2);
      xfer(m, a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)), rd, lat);
    end
  endtask

  task automatic seq_master(input int m, input int n);
    logic [31:0] rd;
    int lat;
    for (int i = 0; i < n; i++) xfer(m, 32'h10, 1'b0, 32'h0, 4'hF, rd, lat);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_chk);
    $fatal(1, "watchdog");
  end

  logic [31:0] rd0, rd1;
  int          lat0, lat1;

  initial begin
    for (int m = 0; m < 2; m++) begin
      adr[m] = '0; dat_i[m] = '0; sel[m] = '0; we[m] = 1'b0;
      cyc[m] = 1'b0; stb[m] = 1'b0; cti[m] = 3'b000;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_we",    32'(ram_we), 0);
    check("rst_waddr", 32'(ram_waddr), 0);
    check("rst_raddr", 32'(ram_raddr), 0);
    check("rst_din",   ram_din, 0);
    check("rst_ack",   32'({ack[1], ack[0]}), 0);
    check("rst_dat0",  dat_o[0], 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // m0 full write then read back
    xfer(0, 32'h0000_0010, 1'b1, 32'hDEADBEEF, 4'hF, rd0, lat0);
    check("wr_lat", lat0, 2);
    xfer(0, 32'h0000_0010, 1'b0, 32'h0, 4'hF, rd0, lat0);
    check("rd_lat", lat0, 2);
    check("rd_word4", rd0, 32'hDEADBEEF);

    // m1 single-byte-lane merge into word 4
    xfer(1, 32'h0000_0010, 1'b1, 32'h0000_AB00, 4'b0010, rd1, lat1);
    xfer(1, 32'h0000_0010, 1'b0, 32'h0, 4'hF, rd1, lat1);
    check("merge_word4", rd1, 32'hDEADABEF);

    // Simultaneous requests: m0 wins the tie, m1 three cycles later
    fork
      xfer(0, 32'h10, 1'b0, 32'h0, 4'hF, rd0, lat0);
      xfer(1, 32'h10, 1'b0, 32'h0, 4'hF, rd1, lat1);
    join
    check("tie_lat_m0", lat0, 2);
    check("tie_lat_m1", lat1, 5);

    // Continuous contention alternates grants
    ackq.delete();
    fork
      seq_master(0, 3);
      seq_master(1, 3);
    join
    check("rr_count", ackq.size(), 6);
    for (int i = 0; i < 6; i++)
      check($sformatf("rr_order%0d", i), (i < ackq.size()) ? ackq[i] : 99, i % 2);

    // Address beyond the RAM aliases onto word 2
    xfer(0, 32'h0000_0408, 1'b1, 32'h1234_5678, 4'hF, rd0, lat0);
    check("alias_waddr", 32'(last_we_addr), 2);
    xfer(1, 32'h0000_0008, 1'b0, 32'h0, 4'hF, rd1, lat1);
    check("alias_rd", rd1, 32'h1234_5678);

    // Reset pulsed in the ADDR cycle of a write to word 8
    adr[0] = 32'h20; dat_i[0] = 32'hAAAA_5555; sel[0] = 4'hF; we[0] = 1'b1;
    cyc[0] = 1'b1; stb[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("addr_we", 32'(ram_we), 32'hF);
    check("addr_waddr", 32'(ram_waddr), 8);
    #2 rst = 1'b1;
    #1;
    check("arst_we", 32'(ram_we), 0);
    check("arst_waddr", 32'(ram_waddr), 0);
    check("arst_din", ram_din, 0);
    check("arst_ack", 32'({ack[1], ack[0]}), 0);
    cyc[0] = 1'b0; stb[0] = 1'b0; we[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("no_ack_after_rst", 32'({ack[1], ack[0]}), 0);
    end
    @(posedge clk); #1;
    xfer(0, 32'h20, 1'b0, 32'h0, 4'hF, rd0, lat0);
    check("post_rst_lat", lat0, 2);
    check("post_rst_word8", rd0, 32'h0);

    // Randomized traffic from both masters over a small address window
    fork
      rand_master(0, 40);
      rand_master(1, 40);
    join
    repeat (3) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
